mac_result_buffer: RTL and testbench
====================================

# mac_result_buffer

Downstream stage of the memory bank. On each cycle the bank asserts `ld_mac`, this block takes the three W/X operand pairs the bank presents and computes their 3-term dot product. It writes one result element per such cycle into a 9-entry result buffer. Once the expected number of elements has been captured, it drains the buffer in row-major order over a valid/ready handshake to the output or writeback logic.

## Interface
- No parameters. Fixed sizing: 4-bit operands, 3 lanes, 9 result entries, 10-bit results.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `data_outw1`, `data_outw2`, `data_outw3` input 4 each: W operands from the memory bank (unsigned).
- `data_outx1`, `data_outx2`, `data_outx3` input 4 each: X operands from the memory bank (unsigned).
- `ld_mac` input 1: when high, the operand triple is valid for this cycle.
- `clear_mac` input 1: synchronous clear of the block; behaves like reset except for priority.
- `res_count` input 4: number of result elements expected (row_w*col_x).
  - Legal range 1..9.
  - Sampled only in IDLE.
- `out_data` output 10: current result element.
- `out_index` output 4: buffer index of `out_data`, 0..8.
- `out_valid` output 1: `out_data` and `out_index` are valid.
- `out_ready` input 1: the consumer accepts the element on this cycle.
- `busy` output 1: high in ACCUM or DRAIN.
- `done` output 1: sticky; all elements have been drained.

## Operation
- Dot product: sum = w1*x1 + w2*x2 + w3*x3.
  - Each product is 8 bits, zero-extended to 10 bits.
  - Maximum value is 675, so there is no overflow.
  - Computed combinationally and registered only into the buffer.
- State machine has 4 states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - Latch `n` = `res_count`, clamped to 9 if greater than 9.
  - If `res_count`=0, remain in IDLE and ignore `ld_mac`.
  - If `ld_mac`=1 and `n`≥1:
    - Write sum to buf[0] and set `wr_ptr`=1.
    - If `n`=1 go to DRAIN, else go to ACCUM.
- ACCUM:
  - Each `ld_mac`=1 cycle: write buf[`wr_ptr`] and increment `wr_ptr`.
  - After the write at `wr_ptr`=`n`-1, go to DRAIN.
  - `ld_mac`=0 cycles are holes: no write, no state change.
- DRAIN:
  - `out_valid`=1, `out_data`=buf[`rd_ptr`], `out_index`=`rd_ptr`.
  - On `out_valid` & `out_ready`, increment `rd_ptr`.
  - Transfer of index `n`-1 → go to DONE.
  - `ld_mac` is ignored.
  - Output values stay stable while `out_ready`=0.
- DONE:
  - `done`=1, `out_valid`=0, `ld_mac` ignored.
  - Stays in DONE until `clear_mac` or reset.
- `clear_mac`=1:
  - From any state, go to IDLE next edge.
  - `wr_ptr`, `rd_ptr` and `done` are cleared.
  - Buffer contents are zeroed.
  - Has priority over `ld_mac` and `out_ready` on the same cycle.
- `rst_n`=0 has the same effect as `clear_mac` and has top priority.

## Timing
- Reset values (after an edge with `rst_n`=0):
  - state=IDLE.
  - `out_valid`=0, `busy`=0, `done`=0.
  - `out_data`=0, `out_index`=0.
  - All buffer entries = 0, `wr_ptr`=`rd_ptr`=0.
- Capture latency: operands valid with `ld_mac` in cycle t are written to the buffer at the end of cycle t.
- First `out_valid`: the cycle after the final capture, i.e. `n` `ld_mac` cycles plus 1.
- Throughput: one element per cycle while `out_ready`=1.
  - With `out_ready` held high, drain takes exactly `n` cycles.
- `done` rises the cycle after the last handshake.
- `busy` is registered from the state: 1 in ACCUM/DRAIN, 0 in IDLE/DONE.
- A mid-operation `clear_mac` or reset abandons the partial results. No `out_valid` pulse follows.
- `res_count` changes after leaving IDLE have no effect.

## Test plan
- 2x2 result, `res_count`=4, `out_ready`=1.
  - Stimulus: operand triples (1,2,3)/(1,1,1), (2,2,2)/(3,3,3), (0,0,0)/(5,5,5), (15,15,15)/(15,15,15).
  - Required: `out_data` 6, 18, 0, 675 at indices 0..3 on 4 consecutive cycles, then `done`=1.
- Holes and backpressure.
  - Stimulus: `res_count`=3, `ld_mac` pattern 1,0,1,0,1; `out_ready` low for 2 cycles on index 1.
  - Required: exactly 3 writes; index 1 held stable for 2 cycles; `done` after the 3rd transfer.
- Full buffer.
  - Stimulus: `res_count`=9, w=x=(1,1,1) for all 9 captures.
  - Required: 9 outputs of value 3 at indices 0..8.
  - Also: `res_count`=12 clamps to 9 results.
- Zero count.
  - Stimulus: `res_count`=0 while `ld_mac` pulses.
  - Required: stays in IDLE, `busy`=0, `out_valid` never asserted.
- Mid-operation clear.
  - Stimulus: `clear_mac` in ACCUM after 2 captures, then in DRAIN with `ld_mac`=1 on the same cycle.
  - Required: IDLE next cycle, pointers 0, `out_valid`=0, no capture.
  - Re-run with `res_count`=1: a single result is produced correctly.
- Reset.
  - Stimulus: `rst_n`=0 in DONE and in DRAIN.
  - Required: all outputs 0 the next cycle; `done` cleared.
  - Reset asserted together with `clear_mac`=0 behaves identically.

Source files
------------

// File: rtl/mac_result_buffer.sv
// mac_result_buffer
//   Takes the three W/X operand pairs from the memory bank on each ld_mac
//   cycle and forms their 3-term dot product. Each product goes into the next
//   slot of a 9-entry result buffer. Once res_count elements have been
//   captured, the buffer is drained in index order over a valid/ready
//   handshake.
// Ports
//   clk, rst_n             : clock, synchronous active-low reset
//   data_outw1..3          : 4-bit unsigned W operands
//   data_outx1..3          : 4-bit unsigned X operands
//   ld_mac                 : operand triple valid this cycle
//   clear_mac              : synchronous clear (below rst_n in priority)
//   res_count              : number of results expected (1..9, >9 clamps to 9)
//   out_data/out_index     : current result element and its buffer index
//   out_valid/out_ready    : drain handshake
//   busy                   : high in ACCUM or DRAIN
//   done                   : high once every element has been drained
module mac_result_buffer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_outw1,
  input  logic [3:0] data_outw2,
  input  logic [3:0] data_outw3,
  input  logic [3:0] data_outx1,
  input  logic [3:0] data_outx2,
  input  logic [3:0] data_outx3,
  input  logic       ld_mac,
  input  logic       clear_mac,
  input  logic [3:0] res_count,
  output logic [9:0] out_data,
  output logic [3:0] out_index,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t     state, state_nx;
  logic [9:0] res_buf [9];
  logic [3:0] wr_ptr, rd_ptr, n_q;
  logic [3:0] n_in;
  logic [7:0] p1, p2, p3;
  logic [9:0] sum;
  logic       wr_en, xfer;

  assign n_in = (res_count > 4'd9) ? 4'd9 : res_count;

  assign p1  = data_outw1 * data_outx1;
  assign p2  = data_outw2 * data_outx2;
  assign p3  = data_outw3 * data_outx3;
  assign sum = {2'b00, p1} + {2'b00, p2} + {2'b00, p3};

  // A count of zero keeps the block parked in IDLE, so ld_mac is ignored there.
  assign wr_en = ld_mac && (((state == IDLE) && (n_in != 4'd0)) || (state == ACCUM));
  assign xfer  = out_valid && out_ready;

  assign out_valid = (state == DRAIN);
  assign busy      = (state == ACCUM) || (state == DRAIN);
  assign done      = (state == DONE);
  // Outside DRAIN, rd_ptr may sit one past the last entry; present zeros instead.
  assign out_data  = out_valid ? res_buf[rd_ptr] : 10'd0;
  assign out_index = out_valid ? rd_ptr : 4'd0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (ld_mac && (n_in != 4'd0))
               state_nx = (n_in == 4'd1) ? DRAIN : ACCUM;
      ACCUM: if (ld_mac && (wr_ptr == n_q - 4'd1))
               state_nx = DRAIN;
      DRAIN: if (out_ready && (rd_ptr == n_q - 4'd1))
               state_nx = DONE;
      DONE:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_mac) begin
      state  <= IDLE;
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      n_q    <= 4'd0;
      for (int i = 0; i < 9; i++) res_buf[i] <= 10'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE) n_q <= n_in;
      if (wr_en) begin
        res_buf[wr_ptr] <= sum;
        wr_ptr          <= wr_ptr + 4'd1;
      end
      if (xfer) rd_ptr <= rd_ptr + 4'd1;
    end
  end

endmodule

// File: tb/tb_mac_result_buffer.sv
module tb_mac_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] w1 = 0, w2 = 0, w3 = 0, x1 = 0, x2 = 0, x3 = 0;
  logic       ld_mac = 1'b0, clear_mac = 1'b0, out_ready = 1'b0;
  logic [3:0] res_count = 4'd0;
  logic [9:0] out_data;
  logic [3:0] out_index;
  logic       out_valid, busy, done;

  int errors = 0;
  int checks = 0;

  mac_result_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .data_outw1(w1), .data_outw2(w2), .data_outw3(w3),
    .data_outx1(x1), .data_outx2(x2), .data_outx3(x3),
    .ld_mac(ld_mac), .clear_mac(clear_mac), .res_count(res_count),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: a list of captured sums, a target count and a count of
  // elements handed over. Expected outputs follow from those counts alone.
  int  m_buf [9];
  int  m_n = 0, m_cap = 0, m_sent = 0;
  bit  m_active = 0, m_done = 0;

  function automatic int dot();
    return int'(w1) * int'(x1) + int'(w2) * int'(x2) + int'(w3) * int'(x3);
  endfunction

  always @(posedge clk) begin
    int n;
    if (!rst_n || clear_mac) begin
      foreach (m_buf[i]) m_buf[i] = 0;
      m_n = 0; m_cap = 0; m_sent = 0; m_active = 0; m_done = 0;
    end else if (!m_active) begin
      n = (res_count > 9) ? 9 : int'(res_count);
      if (ld_mac && n >= 1) begin
        m_n = n; m_buf[0] = dot(); m_cap = 1; m_active = 1;
      end
    end else if (m_cap < m_n) begin
      if (ld_mac) begin m_buf[m_cap] = dot(); m_cap++; end
    end else if (m_sent < m_n) begin
      if (out_ready) begin
        m_sent++;
        if (m_sent == m_n) m_done = 1;
      end
    end
  end

  int got_d[$];
  int got_i[$];

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit ev;
    ev = m_active && (m_cap == m_n) && (m_sent < m_n);
    chk("out_valid", int'(out_valid), int'(ev));
    chk("busy", int'(busy), int'(m_active && !m_done));
    chk("done", int'(done), int'(m_done));
    if (ev && out_valid) begin
      chk("out_data", int'(out_data), m_buf[m_sent]);
      chk("out_index", int'(out_index), m_sent);
    end
    if (out_valid && out_ready) begin
      got_d.push_back(int'(out_data));
      got_i.push_back(int'(out_index));
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int a1, a2, a3, b1, b2, b3);
    w1 = 4'(a1); w2 = 4'(a2); w3 = 4'(a3);
    x1 = 4'(b1); x2 = 4'(b2); x3 = 4'(b3);
    ld_mac = 1'b1;
    tick();
    ld_mac = 1'b0;
  endtask

  task automatic clr();
    clear_mac = 1'b1; tick(); clear_mac = 1'b0;
    got_d.delete(); got_i.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " out_data"}, int'(out_data), 0);
    chk({nm, " out_index"}, int'(out_index), 0);
    chk({nm, " out_valid"}, int'(out_valid), 0);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 0);
  endtask

  int exp4[4] = '{6, 18, 0, 675};
  int exp3[3] = '{6, 24, 45};

  initial begin
    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // 2x2 result, consumer always ready
    res_count = 4'd4; out_ready = 1'b1;
    got_d.delete(); got_i.delete();
    load(1, 2, 3, 1, 1, 1);
    load(2, 2, 2, 3, 3, 3);
    load(0, 0, 0, 5, 5, 5);
    load(15, 15, 15, 15, 15, 15);
    chk("t1 first valid", int'(out_valid), 1);
    tick(5);
    chk("t1 count", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      chk("t1 data", got_d[i], exp4[i]);
      chk("t1 index", got_i[i], i);
    end
    chk("t1 done", int'(done), 1);

    // holes in ld_mac and backpressure on index 1
    clr();
    res_count = 4'd3; out_ready = 1'b1;
    load(1, 1, 1, 2, 2, 2);          // 6
    tick();
    load(2, 2, 2, 4, 4, 4);          // 24
    tick();
    load(3, 3, 3, 5, 5, 5);          // 45
    tick();                          // index 0 transfers
    out_ready = 1'b0;
    tick();
    chk("t2 stall index", int'(out_index), 1);
    chk("t2 stall data", int'(out_data), 24);
    tick();
    chk("t2 stall index 2", int'(out_index), 1);
    out_ready = 1'b1;
    tick(4);
    chk("t2 count", got_d.size(), 3);
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      chk("t2 data", got_d[i], exp3[i]);
      chk("t2 index", got_i[i], i);
    end
    chk("t2 done", int'(done), 1);

    // full buffer, then res_count above 9 clamps
    clr();
    res_count = 4'd9;
    for (int i = 0; i < 9; i++) load(1, 1, 1, 1, 1, 1);
    tick(10);
    chk("t3 count", got_d.size(), 9);
    for (int i = 0; i < 9 && i < got_d.size(); i++) begin
      chk("t3 data", got_d[i], 3);
      chk("t3 index", got_i[i], i);
    end
    clr();
    res_count = 4'd12;
    for (int i = 0; i < 9; i++) load(2, 1, 1, 1, 1, 1);
    chk("t3 clamp valid", int'(out_valid), 1);
    tick(10);
    chk("t3 clamp count", got_d.size(), 9);
    chk("t3 clamp done", int'(done), 1);

    // zero count never leaves IDLE
    clr();
    res_count = 4'd0;
    repeat (4) begin load(1, 1, 1, 1, 1, 1); tick(); end
    chk("t4 busy", int'(busy), 0);
    chk("t4 count", got_d.size(), 0);

    // clear in ACCUM, then in DRAIN alongside ld_mac
    clr();
    res_count = 4'd4; out_ready = 1'b0;
    load(1, 1, 1, 1, 1, 1);
    load(1, 1, 1, 1, 1, 1);
    chk("t5 accum busy", int'(busy), 1);
    clear_mac = 1'b1; ld_mac = 1'b1; tick(); clear_mac = 1'b0; ld_mac = 1'b0;
    chk_zero("t5 clear accum");
    res_count = 4'd2;
    load(1, 1, 1, 1, 1, 1);
    load(1, 1, 1, 1, 1, 1);
    chk("t5 drain valid", int'(out_valid), 1);
    clear_mac = 1'b1; ld_mac = 1'b1; out_ready = 1'b1; tick();
    clear_mac = 1'b0; ld_mac = 1'b0;
    chk_zero("t5 clear drain");
    got_d.delete(); got_i.delete();
    res_count = 4'd1;
    load(5, 0, 0, 3, 0, 0);
    tick(2);
    chk("t5 rerun count", got_d.size(), 1);
    if (got_d.size() > 0) begin
      chk("t5 rerun data", got_d[0], 15);
      chk("t5 rerun index", got_i[0], 0);
    end
    chk("t5 rerun done", int'(done), 1);

    // reset in DONE, then in DRAIN (clear_mac low)
    rst_n = 1'b0; tick(); chk_zero("t6 reset done"); rst_n = 1'b1;
    tick();
    res_count = 4'd2; out_ready = 1'b0;
    load(1, 2, 3, 4, 5, 6);
    load(1, 1, 1, 1, 1, 1);
    chk("t6 drain valid", int'(out_valid), 1);
    chk("t6 drain data", int'(out_data), 32);
    rst_n = 1'b0; tick(); chk_zero("t6 reset drain"); rst_n = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
